// File: rtl/piece_collision_checker.sv
// rtl/piece_collision_checker.sv - reads four board cells and reports whether a tetromino placement collides
// Optional hit_mask_out port enabled by CHECKER_HIT_MASK_EN.
module piece_collision_checker #(
  parameter int MAP_WIDTH   = 14,
  parameter int MAP_HEIGHT  = 24,
  parameter int RAM_LATENCY = 1
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       start_in,
  input  logic [8:0] addr1_in,
  input  logic [8:0] addr2_in,
  input  logic [8:0] addr3_in,
  input  logic [8:0] addr4_in,
  output logic [8:0] ram_addr_out,
  output logic       ram_re_out,
  input  logic [2:0] ram_data_in,
  output logic       busy_out,
  output logic       done_out,
  output logic       collision_out
`ifdef CHECKER_HIT_MASK_EN
  ,
  output logic [3:0] hit_mask_out
`endif
);

  localparam logic [8:0] CELLS = 9'(MAP_WIDTH * MAP_HEIGHT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] lat_addr_q [4];
  logic [8:0] lat_addr_d [4];
  logic [1:0] issue_idx_q, issue_idx_d;
  logic [8:0] ram_addr_q, ram_addr_d;
  logic       ram_re_q, ram_re_d;
  logic [1:0] rd_cnt_q, rd_cnt_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] mask_q, mask_d;

  logic       pipe_vld_q [RAM_LATENCY];
  logic       pipe_vld_d [RAM_LATENCY];
  logic       pipe_ign_q [RAM_LATENCY];
  logic       pipe_ign_d [RAM_LATENCY];
  logic [1:0] pipe_idx_q [RAM_LATENCY];
  logic [1:0] pipe_idx_d [RAM_LATENCY];

  logic [3:0] oor_in;
  logic [3:0] oor_lat;
  logic       sample;
  logic       last_sample;

  function automatic logic [8:0] safe_addr(input logic [8:0] a);
    return (a >= CELLS) ? 9'd0 : a;
  endfunction

  always_comb begin
    oor_in[0] = addr1_in >= CELLS;
    oor_in[1] = addr2_in >= CELLS;
    oor_in[2] = addr3_in >= CELLS;
    oor_in[3] = addr4_in >= CELLS;
    for (int k = 0; k < 4; k++) begin
      oor_lat[k] = lat_addr_q[k] >= CELLS;
    end
  end

  assign sample      = pipe_vld_q[RAM_LATENCY-1];
  assign last_sample = sample && (rd_cnt_q == 2'd3);

  always_comb begin
    state_d     = state_q;
    lat_addr_d  = lat_addr_q;
    issue_idx_d = issue_idx_q;
    ram_addr_d  = ram_addr_q;
    ram_re_d    = 1'b0;
    rd_cnt_d    = rd_cnt_q;
    acc_d       = acc_q;
    mask_d      = mask_q;

    // Each issued read carries its cell index and an ignore flag for out-of-range cells.
    for (int i = RAM_LATENCY - 1; i >= 1; i--) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_ign_d[i] = pipe_ign_q[i-1];
      pipe_idx_d[i] = pipe_idx_q[i-1];
    end
    pipe_vld_d[0] = ram_re_q;
    pipe_ign_d[0] = oor_lat[issue_idx_q];
    pipe_idx_d[0] = issue_idx_q;

    if (sample) begin
      rd_cnt_d = rd_cnt_q + 2'd1;
      if (!pipe_ign_q[RAM_LATENCY-1] && (ram_data_in != 3'd0)) begin
        acc_d[pipe_idx_q[RAM_LATENCY-1]] = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          lat_addr_d[0] = addr1_in;
          lat_addr_d[1] = addr2_in;
          lat_addr_d[2] = addr3_in;
          lat_addr_d[3] = addr4_in;
          acc_d         = oor_in;
          mask_d        = 4'd0;
          rd_cnt_d      = 2'd0;
          issue_idx_d   = 2'd0;
          ram_addr_d    = safe_addr(addr1_in);
          ram_re_d      = 1'b1;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue_idx_q != 2'd3) begin
          issue_idx_d = issue_idx_q + 2'd1;
          ram_addr_d  = safe_addr(lat_addr_q[issue_idx_q + 2'd1]);
          ram_re_d    = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_sample) begin
          mask_d  = acc_d;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      issue_idx_q <= 2'd0;
      ram_addr_q  <= 9'd0;
      ram_re_q    <= 1'b0;
      rd_cnt_q    <= 2'd0;
      acc_q       <= 4'd0;
      mask_q      <= 4'd0;
      for (int k = 0; k < 4; k++) begin
        lat_addr_q[k] <= 9'd0;
      end
      for (int i = 0; i < RAM_LATENCY; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_ign_q[i] <= 1'b0;
        pipe_idx_q[i] <= 2'd0;
      end
    end else begin
      state_q     <= state_d;
      issue_idx_q <= issue_idx_d;
      ram_addr_q  <= ram_addr_d;
      ram_re_q    <= ram_re_d;
      rd_cnt_q    <= rd_cnt_d;
      acc_q       <= acc_d;
      mask_q      <= mask_d;
      for (int k = 0; k < 4; k++) begin
        lat_addr_q[k] <= lat_addr_d[k];
      end
      for (int i = 0; i < RAM_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_d[i];
        pipe_ign_q[i] <= pipe_ign_d[i];
        pipe_idx_q[i] <= pipe_idx_d[i];
      end
    end
  end

  assign ram_addr_out  = ram_addr_q;
  assign ram_re_out    = ram_re_q;
  assign busy_out      = (state_q != S_IDLE);
  assign done_out      = (state_q == S_DONE);
  assign collision_out = |mask_q;
`ifdef CHECKER_HIT_MASK_EN
  assign hit_mask_out  = mask_q;
`endif

endmodule

// File: tb/tb_piece_collision_checker.sv
// tb/tb_piece_collision_checker.sv - directed vector bench for piece_collision_checker
module tb_piece_collision_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, start1;
  logic [8:0] in1 [4];
  logic [8:0] raddr1;
  logic       re1, busy1, done1, coll1;
  logic [2:0] data1;
  logic [3:0] mask1;

  logic       rst3, start3;
  logic [8:0] in3 [4];
  logic [8:0] raddr3;
  logic       re3, busy3, done3, coll3;
  logic [2:0] data3;
  logic [3:0] mask3;

  piece_collision_checker #(.MAP_WIDTH(14), .MAP_HEIGHT(24), .RAM_LATENCY(1)) dut1 (
    .clk_in(clk), .rst_n_in(rst1), .start_in(start1),
    .addr1_in(in1[0]), .addr2_in(in1[1]), .addr3_in(in1[2]), .addr4_in(in1[3]),
    .ram_addr_out(raddr1), .ram_re_out(re1), .ram_data_in(data1),
    .busy_out(busy1), .done_out(done1), .collision_out(coll1)
`ifdef CHECKER_HIT_MASK_EN
    , .hit_mask_out(mask1)
`endif
  );

  piece_collision_checker #(.MAP_WIDTH(14), .MAP_HEIGHT(24), .RAM_LATENCY(3)) dut3 (
    .clk_in(clk), .rst_n_in(rst3), .start_in(start3),
    .addr1_in(in3[0]), .addr2_in(in3[1]), .addr3_in(in3[2]), .addr4_in(in3[3]),
    .ram_addr_out(raddr3), .ram_re_out(re3), .ram_data_in(data3),
    .busy_out(busy3), .done_out(done3), .collision_out(coll3)
`ifdef CHECKER_HIT_MASK_EN
    , .hit_mask_out(mask3)
`endif
  );

`ifndef CHECKER_HIT_MASK_EN
  assign mask1 = 4'd0;
  assign mask3 = 4'd0;
`endif

  // Board RAM models: latency 1 and latency 3.
  logic [2:0] mem1 [512];
  logic [2:0] mem3 [512];
  logic [2:0] rd1;
  logic [2:0] p3 [3];
  always @(posedge clk) begin
    if (re1) rd1 <= mem1[raddr1];
    if (re3) p3[0] <= mem3[raddr3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign data1 = rd1;
  assign data3 = p3[2];

  typedef struct packed {
    logic [3:0][8:0] a;
    logic [8:0]      wcell;
    logic [2:0]      wval;
    logic            exp_coll;
    logic [3:0]      exp_mask;
  } vec_t;

  vec_t vecs [8];
  int tests = 0;
  int fails = 0;

  function automatic vec_t mk(input logic [8:0] a1, input logic [8:0] a2, input logic [8:0] a3,
                              input logic [8:0] a4, input logic [8:0] wc, input logic [2:0] wv,
                              input logic ec, input logic [3:0] em);
    vec_t v;
    v.a[0] = a1; v.a[1] = a2; v.a[2] = a3; v.a[3] = a4;
    v.wcell = wc; v.wval = wv; v.exp_coll = ec; v.exp_mask = em;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem1();
    for (int i = 0; i < 512; i++) mem1[i] = 3'd0;
    mem1[0] = 3'd7;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int cyc;
    logic [8:0] ea;
    clear_mem1();
    if (v.wval != 3'd0) mem1[v.wcell] = v.wval;
    for (int k = 0; k < 4; k++) in1[k] = v.a[k];
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check($sformatf("v%0d_coll_cleared", n), coll1, 0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      ea = (v.a[k] >= 9'd336) ? 9'd0 : v.a[k];
      check($sformatf("v%0d_re_c%0d", n, k + 1), re1, 1);
      check($sformatf("v%0d_addr_c%0d", n, k + 1), raddr1, ea);
    end
    tick();
    cyc = 5;
    check($sformatf("v%0d_re_low_c5", n), re1, 0);
    while (!done1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check($sformatf("v%0d_done_cycle", n), cyc, 6);
    check($sformatf("v%0d_busy_at_done", n), busy1, 1);
    check($sformatf("v%0d_collision", n), coll1, v.exp_coll);
`ifdef CHECKER_HIT_MASK_EN
    check($sformatf("v%0d_hit_mask", n), mask1, v.exp_mask);
`endif
    tick();
    check($sformatf("v%0d_done_pulse_end", n), done1, 0);
    check($sformatf("v%0d_busy_end", n), busy1, 0);
    check($sformatf("v%0d_coll_held", n), coll1, v.exp_coll);
  endtask

  initial begin
    int dcnt, dcyc, bcnt;

    vecs[0] = mk(9'd15,  9'd16,  9'd29,  9'd30,  9'd0,   3'd0, 1'b0, 4'b0000);
    vecs[1] = mk(9'd15,  9'd16,  9'd29,  9'd30,  9'd30,  3'd3, 1'b1, 4'b1000);
    vecs[2] = mk(9'd15,  9'd16,  9'd340, 9'd30,  9'd0,   3'd0, 1'b1, 4'b0100);
    vecs[3] = mk(9'd20,  9'd20,  9'd20,  9'd20,  9'd20,  3'd1, 1'b1, 4'b1111);
    vecs[4] = mk(9'd335, 9'd322, 9'd321, 9'd308, 9'd0,   3'd0, 1'b0, 4'b0000);
    vecs[5] = mk(9'd336, 9'd16,  9'd29,  9'd30,  9'd0,   3'd0, 1'b1, 4'b0001);
    vecs[6] = mk(9'd15,  9'd16,  9'd29,  9'd30,  9'd15,  3'd2, 1'b1, 4'b0001);
    vecs[7] = mk(9'd100, 9'd101, 9'd0,   9'd511, 9'd0,   3'd0, 1'b1, 4'b1100);

    rst1 = 1'b0; rst3 = 1'b0; start1 = 1'b0; start3 = 1'b0;
    for (int k = 0; k < 4; k++) begin in1[k] = 9'd0; in3[k] = 9'd0; end
    clear_mem1();
    for (int i = 0; i < 512; i++) mem3[i] = 3'd0;
    tick();
    tick();
    check("rst_ram_addr", raddr1, 0);
    check("rst_ram_re", re1, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_coll", coll1, 0);
    check("rst_busy_l3", busy3, 0);
    rst1 = 1'b1; rst3 = 1'b1;
    tick();

    for (int n = 0; n < 8; n++) run_vec(vecs[n], n);

    // Start re-asserted in cycles 2 and 6 must be ignored.
    clear_mem1();
    in1[0] = 9'd15; in1[1] = 9'd16; in1[2] = 9'd29; in1[3] = 9'd30;
    start1 = 1'b1;
    dcnt = 0; dcyc = 0; bcnt = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      start1 = (c == 2 || c == 6);
      if (c <= 6 && busy1) bcnt++;
      if (c == 7) check("ign_busy_c7", busy1, 0);
      if (done1) begin dcnt++; dcyc = c; end
    end
    start1 = 1'b0;
    check("ign_busy_c1_6", bcnt, 6);
    check("ign_done_count", dcnt, 1);
    check("ign_done_cycle", dcyc, 6);
    check("ign_coll", coll1, 0);

    // Reset in cycle 3 aborts the check.
    run_vec(vecs[1], 8);
    clear_mem1();
    mem1[16] = 3'd5;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    rst1 = 1'b0;
    tick();
    check("mrst_ram_addr", raddr1, 0);
    check("mrst_ram_re", re1, 0);
    check("mrst_busy", busy1, 0);
    check("mrst_done", done1, 0);
    check("mrst_coll", coll1, 0);
    rst1 = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done1 || busy1) dcnt++;
    end
    check("mrst_no_activity", dcnt, 0);
    run_vec(vecs[0], 9);

    // Latency 3.
    mem3[15] = 3'd7;
    in3[0] = 9'd15; in3[1] = 9'd16; in3[2] = 9'd29; in3[3] = 9'd30;
    start3 = 1'b1;
    dcyc = 0; bcnt = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      start3 = 1'b0;
      if (c <= 8 && busy3) bcnt++;
      if (c == 9) check("l3_busy_c9", busy3, 0);
      if (done3 && dcyc == 0) begin
        dcyc = c;
        check("l3_collision", coll3, 1);
`ifdef CHECKER_HIT_MASK_EN
        check("l3_hit_mask", mask3, 4'b0001);
`endif
      end
    end
    check("l3_done_cycle", dcyc, 8);
    check("l3_busy_c1_8", bcnt, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
